// File: rtl/accel_pkg.sv
// Shared constants, register map and FSM state type for the accelerator controller.
package accel_pkg;

    localparam int TIMEOUT_DEFAULT = 1024;

    localparam logic [7:0] CTRL_OFS   = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;
    localparam logic [7:0] KEY_BASE   = 8'h20;
    localparam logic [7:0] DIN_BASE   = 8'h40;
    localparam logic [7:0] DOUT_BASE  = 8'h60;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_ERR     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) merged[8*b +: 8] = new_w[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/accel_wb_ctrl_if.sv
// Wishbone slave-side signal bundle between the wrapper bus and the accelerator controller.
interface accel_wb_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/accel_wb_regs.sv
// Wishbone decode, registered ack, byte-masked KEY/DIN/IRQ_EN storage, DOUT capture and readback.
module accel_wb_regs
    import accel_pkg::*;
#(
    parameter int KEY_WORDS  = 8,
    parameter int DATA_WORDS = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    accel_wb_ctrl_if.slave          wbs,
    input  logic                    i_busy,
    input  logic [3:0]              i_status,
    input  logic                    i_cap_en,
    input  logic [32*DATA_WORDS-1:0] i_cap_data,
    output logic                    o_start_req,
    output logic                    o_clr_req,
    output logic                    o_busy_viol,
    output logic                    o_irq_en,
    output logic [32*KEY_WORDS-1:0] o_key,
    output logic [32*DATA_WORDS-1:0] o_din
);

    localparam int KEY_W  = int'(KEY_BASE) >> 2;
    localparam int DIN_W  = int'(DIN_BASE) >> 2;
    localparam int DOUT_W = int'(DOUT_BASE) >> 2;

    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  r_irq_en;
    logic [31:0]           r_key  [KEY_WORDS];
    logic [31:0]           r_din  [DATA_WORDS];
    logic [31:0]           r_dout [DATA_WORDS];

    logic [5:0]            w_widx;
    logic                  w_req;
    logic                  w_wr;
    logic                  w_ctrl_hit;
    logic                  w_status_hit;
    logic [KEY_WORDS-1:0]  w_key_hit;
    logic [DATA_WORDS-1:0] w_din_hit;
    logic [DATA_WORDS-1:0] w_dout_hit;
    logic [31:0]           w_rdata;
    logic                  w_unused_adr;

    // Only the word index is decoded, so higher address bits alias.
    assign w_widx       = wbs.wbs_adr_i[7:2];
    assign w_unused_adr = ^{wbs.wbs_adr_i[31:8], wbs.wbs_adr_i[1:0]};
    assign w_req        = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
    assign w_wr         = w_req & wbs.wbs_we_i;
    assign w_ctrl_hit   = (w_widx == CTRL_OFS[7:2]);
    assign w_status_hit = (w_widx == STATUS_OFS[7:2]);

    for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key
        assign w_key_hit[gi]       = (w_widx == 6'(KEY_W + gi));
        assign o_key[32*gi +: 32]  = r_key[gi];
    end

    for (genvar gi = 0; gi < DATA_WORDS; gi++) begin : g_data
        assign w_din_hit[gi]       = (w_widx == 6'(DIN_W + gi));
        assign w_dout_hit[gi]      = (w_widx == 6'(DOUT_W + gi));
        assign o_din[32*gi +: 32]  = r_din[gi];
    end

    assign o_start_req = w_wr & w_ctrl_hit & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CTRL_START];
    assign o_clr_req   = w_wr & w_ctrl_hit & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CTRL_CLR];
    assign o_busy_viol = w_wr & i_busy & ((|w_key_hit) | (|w_din_hit));
    assign o_irq_en    = r_irq_en;

    always_comb begin
        w_rdata = '0;
        if (w_ctrl_hit)   w_rdata[CTRL_IRQ_EN] = r_irq_en;
        if (w_status_hit) w_rdata[3:0]         = i_status;
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (w_key_hit[i]) w_rdata = r_key[i];
        end
        for (int i = 0; i < DATA_WORDS; i++) begin
            if (w_din_hit[i])  w_rdata = r_din[i];
            if (w_dout_hit[i]) w_rdata = r_dout[i];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs.wbs_we_i) ? w_rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_en <= 1'b0;
            for (int i = 0; i < KEY_WORDS; i++) r_key[i] <= '0;
            for (int i = 0; i < DATA_WORDS; i++) begin
                r_din[i]  <= '0;
                r_dout[i] <= '0;
            end
        end else begin
            if (w_wr && w_ctrl_hit && wbs.wbs_sel_i[0]) r_irq_en <= wbs.wbs_dat_i[CTRL_IRQ_EN];
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (w_wr && w_key_hit[i] && !i_busy)
                    r_key[i] <= byte_merge(r_key[i], wbs.wbs_dat_i, wbs.wbs_sel_i);
            end
            for (int i = 0; i < DATA_WORDS; i++) begin
                if (w_wr && w_din_hit[i] && !i_busy)
                    r_din[i] <= byte_merge(r_din[i], wbs.wbs_dat_i, wbs.wbs_sel_i);
                if (i_cap_en) r_dout[i] <= i_cap_data[32*i +: 32];
            end
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

endmodule

// File: rtl/accel_wb_ctrl.sv
// Sequences the crypto core: start pulse, bounded wait for completion, status flags and level irq.
module accel_wb_ctrl
    import accel_pkg::*;
#(
    parameter int KEY_WORDS  = 8,
    parameter int DATA_WORDS = 4,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    accel_wb_ctrl_if.slave           wbs,
    output logic                     core_start_o,
    output logic [32*KEY_WORDS-1:0]  core_key_o,
    output logic [32*DATA_WORDS-1:0] core_din_o,
    input  logic                     core_done_i,
    input  logic [32*DATA_WORDS-1:0] core_dout_i,
    output logic                     irq_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_timeout;
    logic             r_err;
    logic             r_start;
    logic             r_irq;

    logic             w_busy;
    logic             w_cap_en;
    logic             w_start_req;
    logic             w_clr_req;
    logic             w_busy_viol;
    logic             w_irq_en;
    logic [3:0]       w_status;

    assign w_busy   = (r_state == S_START) || (r_state == S_WAIT);
    assign w_cap_en = (r_state == S_WAIT) && core_done_i;

    always_comb begin
        w_status             = '0;
        w_status[ST_BUSY]    = w_busy;
        w_status[ST_DONE]    = r_done;
        w_status[ST_TIMEOUT] = r_timeout;
        w_status[ST_ERR]     = r_err;
    end

    accel_wb_regs #(
        .KEY_WORDS  (KEY_WORDS),
        .DATA_WORDS (DATA_WORDS)
    ) u_regs (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs         (wbs),
        .i_busy      (w_busy),
        .i_status    (w_status),
        .i_cap_en    (w_cap_en),
        .i_cap_data  (core_dout_i),
        .o_start_req (w_start_req),
        .o_clr_req   (w_clr_req),
        .o_busy_viol (w_busy_viol),
        .o_irq_en    (w_irq_en),
        .o_key       (core_key_o),
        .o_din       (core_din_o)
    );

    // CLR is applied before the state transition so a combined CLR+START leaves err clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_clr_req) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
                r_err     <= 1'b0;
            end
            if (w_busy_viol || (w_busy && w_start_req)) r_err <= 1'b1;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_req) begin
                        r_state   <= S_START;
                        r_start   <= 1'b1;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end else if (w_clr_req) begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the expiry cycle still counts as a normal finish.
                    if (core_done_i) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            r_irq <= r_done & w_irq_en;
        end
    end

    assign core_start_o = r_start;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_accel_wb_ctrl.sv
// Directed plus randomized bench for accel_wb_ctrl against a register-map level reference model.
module tb_accel_wb_ctrl;

    localparam int KW  = 8;
    localparam int DW  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accel_wb_ctrl_if wbs ();

    logic              core_start;
    logic [32*KW-1:0]  core_key;
    logic [32*DW-1:0]  core_din;
    logic              core_done = 1'b0;
    logic [32*DW-1:0]  core_dout = '0;
    logic              irq;

    accel_wb_ctrl #(
        .KEY_WORDS  (KW),
        .DATA_WORDS (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs          (wbs),
        .core_start_o (core_start),
        .core_key_o   (core_key),
        .core_din_o   (core_din),
        .core_done_i  (core_done),
        .core_dout_i  (core_dout),
        .irq_o        (irq)
    );

    int n_assert  = 0;
    int n_fail    = 0;
    int start_cnt = 0;

    // Reference model of the programmer-visible state.
    logic [31:0] m_key  [KW];
    logic [31:0] m_din  [DW];
    logic [31:0] m_dout [DW];
    bit m_irq_en, m_done, m_tmo, m_err, m_busy;

    always @(negedge clk) if (core_start === 1'b1) start_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < KW; i++) m_key[i] = '0;
        for (int i = 0; i < DW; i++) begin
            m_din[i]  = '0;
            m_dout[i] = '0;
        end
        m_irq_en = 0; m_done = 0; m_tmo = 0; m_err = 0; m_busy = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] adr);
        int w;
        w = int'(adr[7:2]);
        if (w == 0) return {30'b0, m_irq_en, 1'b0};
        if (w == 1) return {28'b0, m_err, m_tmo, m_done, m_busy};
        if (w >= 'h20/4 && w < 'h20/4 + KW) return m_key[w - 'h20/4];
        if (w >= 'h40/4 && w < 'h40/4 + DW) return m_din[w - 'h40/4];
        if (w >= 'h60/4 && w < 'h60/4 + DW) return m_dout[w - 'h60/4];
        return 32'h0;
    endfunction

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        bit got;
        got = 0;
        rd  = 'x;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_adr_i = adr;
        wbs.wbs_dat_i = dat;
        wbs.wbs_sel_i = sel;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk);
            #1;
            if (wbs.wbs_ack_o === 1'b1) begin
                got = 1;
                rd  = wbs.wbs_dat_o;
            end
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        if (!got) check("ack_received", 32'd0, 32'd1);
        $display("wb %s adr=0x%02h dat=0x%08h sel=%b", we ? "wr" : "rd", adr[7:0], we ? dat : rd, sel);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] adr);
        logic [31:0] v;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, v);
        check(tag, v, exp_read(adr));
    endtask

    task automatic pulse_done(input logic [32*DW-1:0] d);
        core_done = 1'b1;
        core_dout = d;
        tick(1);
        core_done = 1'b0;
        core_dout = {DW{$urandom}};
    endtask

    // CTRL write with START: applies CLR first, then a start from idle/done clears done/timeout.
    task automatic model_ctrl(input logic [31:0] v);
        m_irq_en = v[1];
        if (v[2]) begin m_done = 0; m_tmo = 0; m_err = 0; end
        if (v[0]) begin
            if (m_busy) m_err = 1;
            else begin m_busy = 1; m_done = 0; m_tmo = 0; end
        end
    endtask

    initial begin
        logic [31:0]      v;
        logic [32*DW-1:0] d;
        int               sc, lat, idx;
        logic [3:0]       sel;

        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0; wbs.wbs_we_i = 0;
        wbs.wbs_sel_i = 0; wbs.wbs_adr_i = 0; wbs.wbs_dat_i = 0;
        model_reset();

        // Reset state
        tick(2);
        rst = 1'b0;
        check("rst_ack", {31'b0, wbs.wbs_ack_o}, 32'd0);
        check("rst_dat", wbs.wbs_dat_o, 32'd0);
        check("rst_start", {31'b0, core_start}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_key0", core_key[31:0], 32'd0);
        rd_check("rst_status", 32'h04);

        // Nominal operation
        for (int i = 0; i < KW; i++) begin
            wr(32'h20 + 4*i, 32'h1000 + i, 4'hF);
            m_key[i] = 32'h1000 + i;
        end
        for (int i = 0; i < DW; i++) begin
            wr(32'h40 + 4*i, 32'hA0 + i, 4'hF);
            m_din[i] = 32'hA0 + i;
        end
        check("key_o_w0", core_key[31:0], 32'h1000);
        check("din_o_w3", core_din[127:96], 32'hA3);
        sc = start_cnt;
        wr(32'h00, 32'h3, 4'hF);
        model_ctrl(32'h3);
        tick(3);
        check("start_one_pulse", start_cnt - sc, 32'd1);
        tick(9);
        d = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        pulse_done(d);
        for (int i = 0; i < DW; i++) m_dout[i] = d[32*i +: 32];
        m_done = 1; m_busy = 0;
        tick(1);
        check("nom_irq", {31'b0, irq}, 32'd1);
        rd_check("nom_dout0", 32'h60);
        check("nom_dout0_const", exp_read(32'h60), 32'hDEADBEEF);
        rd_check("nom_dout3", 32'h6C);
        rd_check("nom_status", 32'h04);
        wr(32'h00, 32'h4, 4'hF);
        model_ctrl(32'h4);
        tick(1);
        check("clr_irq", {31'b0, irq}, 32'd0);
        rd_check("clr_status", 32'h04);

        // Timeout: done/timeout must appear exactly TMO cycles after WAIT entry
        sc = start_cnt;
        wr(32'h00, 32'h3, 4'hF);
        model_ctrl(32'h3);
        tick(TMO + 1);
        check("tmo_irq_not_yet", {31'b0, irq}, 32'd0);
        tick(1);
        check("tmo_irq", {31'b0, irq}, 32'd1);
        m_done = 1; m_tmo = 1; m_busy = 0;
        rd_check("tmo_status", 32'h04);
        rd_check("tmo_dout0_kept", 32'h60);
        check("tmo_start_pulse", start_cnt - sc, 32'd1);

        // Busy protection
        wr(32'h00, 32'h7, 4'hF);
        model_ctrl(32'h7);
        sc = start_cnt;
        wr(32'h44, 32'h55, 4'hF);
        m_err = 1;
        rd_check("busy_din1", 32'h44);
        rd_check("busy_status", 32'h04);
        wr(32'h00, 32'h3, 4'hF);
        model_ctrl(32'h3);
        tick(3);
        check("busy_no_restart", start_cnt - sc, 32'd1);
        d = {DW{$urandom}};
        pulse_done(d);
        for (int i = 0; i < DW; i++) m_dout[i] = d[32*i +: 32];
        m_done = 1; m_busy = 0;
        rd_check("busy_status_after", 32'h04);
        rd_check("busy_dout2", 32'h68);
        wr(32'h00, 32'h4, 4'hF);
        model_ctrl(32'h4);

        // Byte enables, sel on CTRL, unmapped addresses
        wr(32'h28, 32'h0, 4'hF);
        wr(32'h28, 32'hAABBCCDD, 4'b0101);
        m_key[2] = 32'h00BB00DD;
        rd_check("sel_key2", 32'h28);
        check("sel_key2_o", core_key[95:64], 32'h00BB00DD);
        sc = start_cnt;
        wr(32'h00, 32'h3, 4'h0);
        tick(2);
        check("sel0_no_start", start_cnt - sc, 32'd0);
        rd_check("sel0_ctrl", 32'h00);
        wr(32'h84, 32'h12345678, 4'hF);
        rd_check("unmapped_84", 32'h84);
        rd_check("unmapped_10", 32'h10);

        // Back-to-back strobes: ack alternates, one cycle wide
        tick(1);
        wbs.wbs_cyc_i = 1; wbs.wbs_stb_i = 1; wbs.wbs_we_i = 0;
        wbs.wbs_adr_i = 32'h20; wbs.wbs_sel_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check($sformatf("b2b_ack%0d", i), {31'b0, wbs.wbs_ack_o}, {31'b0, (i % 2) == 0});
            $display("wb rd adr=0x20 b2b cycle %0d ack=%0b dat=0x%08h", i, wbs.wbs_ack_o, wbs.wbs_dat_o);
        end
        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0;
        tick(1);

        // Collision: core done in the expiry cycle
        wr(32'h00, 32'h3, 4'hF);
        model_ctrl(32'h3);
        tick(TMO);
        d = {DW{$urandom}};
        pulse_done(d);
        for (int i = 0; i < DW; i++) m_dout[i] = d[32*i +: 32];
        m_done = 1; m_tmo = 0; m_busy = 0;
        rd_check("coll_status", 32'h04);
        rd_check("coll_dout0", 32'h60);
        rd_check("coll_dout1", 32'h64);

        // Randomized register traffic and operations
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    v   = $urandom;
                    sel = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) begin
                        idx = $urandom_range(0, KW - 1);
                        wr(32'h20 + 4*idx, v, sel);
                        m_key[idx] = merge(m_key[idx], v, sel);
                    end else begin
                        idx = $urandom_range(0, DW - 1);
                        wr(32'h40 + 4*idx, v, sel);
                        m_din[idx] = merge(m_din[idx], v, sel);
                    end
                end
                1: begin
                    v = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                    rd_check($sformatf("rand_rd_%02h", v[7:0]), v);
                end
                2: begin
                    v = {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
                    wr(32'h00, v, 4'hF);
                    model_ctrl(v);
                    if ($urandom_range(0, 2) != 0) begin
                        lat = $urandom_range(1, 10);
                        tick(lat);
                        d = {DW{$urandom}};
                        pulse_done(d);
                        for (int i = 0; i < DW; i++) m_dout[i] = d[32*i +: 32];
                        m_tmo = 0;
                    end else begin
                        tick(TMO + 4);
                        m_tmo = 1;
                    end
                    m_done = 1; m_busy = 0;
                    tick(1);
                    check("rand_irq", {31'b0, irq}, {31'b0, m_done & m_irq_en});
                    rd_check("rand_status", 32'h04);
                    rd_check("rand_dout", 32'h60 + 4*$urandom_range(0, DW - 1));
                end
                default: begin
                    for (int i = 0; i < KW; i++) check($sformatf("rand_key_o%0d", i), core_key[32*i +: 32], m_key[i]);
                    for (int i = 0; i < DW; i++) check($sformatf("rand_din_o%0d", i), core_din[32*i +: 32], m_din[i]);
                end
            endcase
        end

        // Reset asserted mid-WAIT
        wr(32'h00, 32'h3, 4'hF);
        tick(4);
        rst = 1'b1;
        tick(2);
        check("mid_rst_start", {31'b0, core_start}, 32'd0);
        check("mid_rst_irq", {31'b0, irq}, 32'd0);
        check("mid_rst_ack", {31'b0, wbs.wbs_ack_o}, 32'd0);
        check("mid_rst_dat", wbs.wbs_dat_o, 32'd0);
        check("mid_rst_key0", core_key[31:0], 32'd0);
        check("mid_rst_din0", core_din[31:0], 32'd0);
        rst = 1'b0;
        model_reset();
        rd_check("mid_rst_status", 32'h04);
        sc = start_cnt;
        pulse_done({DW{32'hCAFEF00D}});
        rd_check("late_done_dout0", 32'h60);
        rd_check("late_done_status", 32'h04);
        check("late_done_no_start", start_cnt - sc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
